age_matrix_select: RTL

Parametrised, synthesizable oldest-first issue selector for the issue queue, the successor to the simulation-only active-list walker. It tracks relative age with an IQ_DEPTH×IQ_DEPTH age matrix updated at dispatch, so no active-list walk is needed. Each cycle it produces, per issue lane, a one-hot grant for the oldest requesting entry of that lane's FU type. Predicted-violating loads are held until they fall within a configurable age window. It sits between the wakeup/request logic and the per-lane select/payload read.

---
 rtl/age_matrix_select_pkg.sv | 27 ++
 rtl/age_matrix_select_if.sv | 31 +++
 rtl/age_matrix_select_lane_pick.sv | 20 ++
 rtl/age_matrix_select.sv | 107 ++++++++++
 4 files changed

// File: rtl/age_matrix_select_pkg.sv
// Shared sizing, types and helpers for the age-matrix issue selector.
package age_matrix_select_pkg;
  localparam int IQ_DEPTH     = 32;
  localparam int DISPATCH_W   = 4;
  localparam int ISSUE_W      = 5;
  localparam int STRUCT_PARTS = 2;
  localparam int IQ_DEPTH_LOG = $clog2(IQ_DEPTH);
  localparam int ISSUE_W_LOG  = $clog2(ISSUE_W);
  // Partitions are contiguous entry ranges of equal size.
  localparam int PART_SZ      = IQ_DEPTH / STRUCT_PARTS;

  typedef enum logic [ISSUE_W_LOG-1:0] {
    FU_SIMPLE  = 3'd0,
    FU_COMPLEX = 3'd1,
    FU_BRANCH  = 3'd2,
    FU_LOAD    = 3'd3,
    FU_STORE   = 3'd4
  } fu_e;

  typedef logic [IQ_DEPTH-1:0] iq_vec_t;

  function automatic logic [IQ_DEPTH_LOG:0] popcount(input iq_vec_t v);
    popcount = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      popcount = popcount + (IQ_DEPTH_LOG+1)'(v[i]);
  endfunction
endpackage

// File: rtl/age_matrix_select_if.sv
// Dispatch/issue/request bus into the selector and per-lane grants out.
interface age_matrix_select_if;
  import age_matrix_select_pkg::*;

  logic                                      flush_i;
  logic                                      backEndReady_i;
  logic [DISPATCH_W-1:0]                     dispValid_i;
  logic [DISPATCH_W-1:0][IQ_DEPTH_LOG-1:0]   dispEntry_i;
  logic [DISPATCH_W-1:0][ISSUE_W_LOG-1:0]    dispFu_i;
  logic [DISPATCH_W-1:0]                     dispIsLoad_i;
  logic [DISPATCH_W-1:0]                     dispPredVio_i;
  logic [ISSUE_W-1:0]                        issueValid_i;
  logic [ISSUE_W-1:0][IQ_DEPTH_LOG-1:0]      issueEntry_i;
  logic [STRUCT_PARTS-1:0]                   partActive_i;
  logic [IQ_DEPTH-1:0]                       requestVector_i;
  logic [ISSUE_W-1:0][IQ_DEPTH-1:0]          agedReqVector_o;
  logic [ISSUE_W-1:0]                        grantValid_o;

  modport master (
    output flush_i, backEndReady_i, dispValid_i, dispEntry_i, dispFu_i,
           dispIsLoad_i, dispPredVio_i, issueValid_i, issueEntry_i,
           partActive_i, requestVector_i,
    input  agedReqVector_o, grantValid_o
  );
  modport slave (
    input  flush_i, backEndReady_i, dispValid_i, dispEntry_i, dispFu_i,
           dispIsLoad_i, dispPredVio_i, issueValid_i, issueEntry_i,
           partActive_i, requestVector_i,
    output agedReqVector_o, grantValid_o
  );
endinterface

// File: rtl/age_matrix_select_lane_pick.sv
// One issue lane: grant the eligible entry of this lane's FU with no older eligible peer.
module age_lane_pick
  import age_matrix_select_pkg::*;
(
  input  logic [IQ_DEPTH-1:0]                  elig,
  input  logic [IQ_DEPTH-1:0][ISSUE_W_LOG-1:0] fu,
  input  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]    age,
  input  logic [ISSUE_W_LOG-1:0]               lane,
  output logic [IQ_DEPTH-1:0]                  grant
);
  logic [IQ_DEPTH-1:0] cand;

  for (genvar e = 0; e < IQ_DEPTH; e++) begin : g_cand
    assign cand[e] = elig[e] & (fu[e] == lane);
  end

  for (genvar e = 0; e < IQ_DEPTH; e++) begin : g_grant
    assign grant[e] = cand[e] & ~|(cand & age[e]);
  end
endmodule

// File: rtl/age_matrix_select.sv
// Oldest-first issue select: age matrix written at dispatch, per-lane one-hot grants.
module age_matrix_select
  import age_matrix_select_pkg::*;
#(
  parameter int LD_WINDOW    = 16,
  parameter int LD_STALL_ALL = 0,
  parameter int OUT_REG      = 0
) (
  input logic                clk,
  input logic                reset,
  age_matrix_select_if.slave bus
);
  localparam logic [IQ_DEPTH_LOG:0] WIN = (IQ_DEPTH_LOG+1)'(LD_WINDOW);

  iq_vec_t valid, valid_n, valid_ai, hold, hold_n, elig, all_hot, prior;
  logic [IQ_DEPTH-1:0][ISSUE_W_LOG-1:0] fu, fu_n;
  logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]    age, age_n;
  logic [DISPATCH_W-1:0][IQ_DEPTH-1:0]  wr_hot;
  logic [ISSUE_W-1:0][IQ_DEPTH-1:0]     grant, out_vec;
  logic                                 dup;

  always_comb begin
    valid_ai = valid;
    for (int l = 0; l < ISSUE_W; l++)
      if (bus.issueValid_i[l]) valid_ai[bus.issueEntry_i[l]] = 1'b0;

    all_hot = '0;
    dup     = 1'b0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      wr_hot[k] = (bus.backEndReady_i && bus.dispValid_i[k]) ?
                  (iq_vec_t'(1) << bus.dispEntry_i[k]) : '0;
      dup       = dup | (|(all_hot & wr_hot[k]));
      all_hot   = all_hot | wr_hot[k];
    end

    valid_n = valid_ai | all_hot;
    fu_n    = fu;
    hold_n  = hold;
    // New entries are younger than everything, so clear their column elsewhere.
    for (int r = 0; r < IQ_DEPTH; r++)
      age_n[r] = all_hot[r] ? age[r] : (age[r] & ~all_hot);

    // Older = survivors not being rewritten, plus entries from earlier slots.
    prior = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      if (|wr_hot[k]) begin
        fu_n[bus.dispEntry_i[k]]   = bus.dispFu_i[k];
        hold_n[bus.dispEntry_i[k]] = bus.dispIsLoad_i[k] &
                                     (bus.dispPredVio_i[k] | (LD_STALL_ALL != 0));
        age_n[bus.dispEntry_i[k]]  = (valid_ai & ~all_hot) | prior;
      end
      prior = prior | wr_hot[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= '0;
      fu    <= '0;
      hold  <= '0;
      age   <= '0;
    end else if (bus.flush_i) begin
      valid <= '0;
    end else begin
      valid <= valid_n;
      fu    <= fu_n;
      hold  <= hold_n;
      age   <= age_n;
    end
  end

  for (genvar e = 0; e < IQ_DEPTH; e++) begin : g_elig
    logic [IQ_DEPTH_LOG:0] older_cnt;
    assign older_cnt = popcount(age[e] & valid);
    assign elig[e]   = valid[e] & bus.requestVector_i[e] & bus.partActive_i[e / PART_SZ] &
                       ~(hold[e] & (older_cnt > WIN));
  end

  for (genvar l = 0; l < ISSUE_W; l++) begin : g_lane
    age_lane_pick u_pick (
      .elig  (elig),
      .fu    (fu),
      .age   (age),
      .lane  (ISSUE_W_LOG'(l)),
      .grant (grant[l])
    );
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [ISSUE_W-1:0][IQ_DEPTH-1:0] grant_q;
    always_ff @(posedge clk) begin
      if (!reset)           grant_q <= '0;
      else if (bus.flush_i) grant_q <= '0;
      else                  grant_q <= grant;
    end
    assign out_vec = grant_q;
  end else begin : g_ocomb
    assign out_vec = grant;
  end

  assign bus.agedReqVector_o = out_vec;
  for (genvar l = 0; l < ISSUE_W; l++) begin : g_gv
    assign bus.grantValid_o[l] = |out_vec[l];
  end

  a_no_dup_write: assert property (@(posedge clk) disable iff (!reset) !dup);
endmodule
